// File: rtl/addr4u_redundant_sched.sv
// Two-requester scheduler for a shared external 4-bit adder. Each operation is
// run twice with swapped operands and the two results are compared.
module addr4u_redundant_sched #(
    parameter int MAX_RETRY = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic [1:0] gnt,
    output logic [3:0] add_a,
    output logic [3:0] add_b,
    input  logic [4:0] add_o,
    output logic       resp_valid,
    output logic       resp_id,
    output logic [4:0] resp_sum,
    output logic       resp_fault,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, PASS1, PASS2, CHECK} state_t;

    localparam logic [2:0] MAX_R = 3'(MAX_RETRY);

    state_t     state, state_nx;
    logic       ptr;
    logic       cur_id;
    logic [2:0] retry_cnt;
    logic [3:0] op_a, op_b;
    logic [4:0] r1, r2;

    logic       win_id;
    logic       grant_en;
    logic       resp_en;
    logic       fault_nx;
    logic       retry_inc;

    // Only a simultaneous request consults the last-served pointer.
    always_comb begin
        win_id = 1'b0;
        if (req == 2'b10)
            win_id = 1'b1;
        else if (req == 2'b11)
            win_id = ~ptr;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        add_a     = 4'd0;
        add_b     = 4'd0;
        grant_en  = 1'b0;
        resp_en   = 1'b0;
        fault_nx  = 1'b0;
        retry_inc = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    grant_en = 1'b1;
                    state_nx = PASS1;
                end
            end
            PASS1: begin
                add_a    = op_a;
                add_b    = op_b;
                state_nx = PASS2;
            end
            PASS2: begin
                add_a    = op_b;
                add_b    = op_a;
                state_nx = CHECK;
            end
            CHECK: begin
                if (r1 == r2) begin
                    resp_en  = 1'b1;
                    state_nx = IDLE;
                end else if (retry_cnt < MAX_R) begin
                    retry_inc = 1'b1;
                    state_nx  = PASS1;
                end else begin
                    resp_en  = 1'b1;
                    fault_nx = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // Control and response registers; strobes default low every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt        <= 2'b00;
            resp_valid <= 1'b0;
            resp_fault <= 1'b0;
            resp_id    <= 1'b0;
            resp_sum   <= 5'd0;
            retry_cnt  <= 3'd0;
            ptr        <= 1'b1;
            cur_id     <= 1'b0;
        end else begin
            gnt        <= 2'b00;
            resp_valid <= 1'b0;
            if (grant_en) begin
                gnt       <= win_id ? 2'b10 : 2'b01;
                ptr       <= win_id;
                cur_id    <= win_id;
                retry_cnt <= 3'd0;
            end
            if (retry_inc)
                retry_cnt <= retry_cnt + 3'd1;
            if (resp_en) begin
                resp_valid <= 1'b1;
                resp_sum   <= r1;
                resp_id    <= cur_id;
                resp_fault <= fault_nx;
            end
        end
    end

    // Operand and pass-result registers carry no reset; they are always
    // written before being used.
    always_ff @(posedge clk) begin
        if (grant_en) begin
            op_a <= win_id ? a1 : a0;
            op_b <= win_id ? b1 : b0;
        end
        if (state == PASS1)
            r1 <= add_o;
        if (state == PASS2)
            r2 <= add_o;
    end

endmodule

// File: tb/tb_addr4u_redundant_sched.sv
// Directed bench for addr4u_redundant_sched: vector table plus hand-written
// sequences for reset abort, back-to-back arbitration and busy-time requests.
module tb_addr4u_redundant_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] req;
    logic [3:0] a0, b0, a1, b1;
    logic [1:0] gnt;
    logic [3:0] add_a, add_b;
    logic [4:0] add_o;
    logic       resp_valid, resp_id, resp_fault, busy;
    logic [4:0] resp_sum;

    int   mode = 0;       // 0 ideal, 1 one-shot fault, 2 persistent fault
    logic used = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    addr4u_redundant_sched #(.MAX_RETRY(2)) dut (
        .clk(clk), .rst(rst), .req(req),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt(gnt), .add_a(add_a), .add_b(add_b), .add_o(add_o),
        .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_sum(resp_sum), .resp_fault(resp_fault), .busy(busy)
    );

    // External adder model; the fault forces bit0 high on the swapped pass
    // (operands chosen so that add_a > add_b only there).
    always_comb begin
        add_o = {1'b0, add_a} + {1'b0, add_b};
        if ((mode == 2 || (mode == 1 && !used)) && add_a > add_b)
            add_o[0] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (mode != 1)
            used <= 1'b0;
        else if (add_a > add_b)
            used <= 1'b1;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    typedef struct {
        logic [1:0] req;
        logic [3:0] a0, b0, a1, b1;
        int         mode;
        logic [1:0] gnt;
        logic       id;
        logic [4:0] sum;
        logic       fault;
        int         lat;
    } vec_t;

    vec_t vecs[8];

    task automatic run_op(input vec_t v);
        bit got;
        int lat;
        @(negedge clk);
        mode = v.mode;
        req  = v.req;
        a0 = v.a0; b0 = v.b0; a1 = v.a1; b1 = v.b1;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) got = 1;
        end
        if (!got) begin
            check("gnt_timeout", 32'd0, 32'd1);
            req = 2'b00;
            return;
        end
        check("gnt", 32'(gnt), 32'(v.gnt));
        req = 2'b00;
        lat = 0;
        got = 0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (lat == 1) check("gnt_pulse", 32'(gnt), 32'd0);
            if (resp_valid) got = 1;
        end
        if (!got) begin
            check("resp_timeout", 32'd0, 32'd1);
            return;
        end
        check("latency", 32'(lat), 32'(v.lat));
        check("resp_sum", 32'(resp_sum), 32'(v.sum));
        check("resp_id", 32'(resp_id), 32'(v.id));
        check("resp_fault", 32'(resp_fault), 32'(v.fault));
        @(negedge clk);
        check("rv_pulse", 32'(resp_valid), 32'd0);
        check("sum_hold", 32'(resp_sum), 32'(v.sum));
    endtask

    task automatic wait_gnt(output bit got);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (gnt != 2'b00) got = 1;
        end
        if (!got) check("gnt_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        check("drain_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        bit got;
        logic [1:0] eg;
        //        req    a0     b0     a1     b1     md gnt    id    sum     flt lat
        vecs[0] = '{2'b01, 4'd9,  4'd7,  4'd0,  4'd0,  0, 2'b01, 1'b0, 5'd16, 1'b0, 3};
        vecs[1] = '{2'b10, 4'd0,  4'd0,  4'd15, 4'd15, 0, 2'b10, 1'b1, 5'd30, 1'b0, 3};
        vecs[2] = '{2'b01, 4'd15, 4'd1,  4'd0,  4'd0,  0, 2'b01, 1'b0, 5'd16, 1'b0, 3};
        vecs[3] = '{2'b11, 4'd1,  4'd1,  4'd8,  4'd8,  0, 2'b10, 1'b1, 5'd16, 1'b0, 3};
        vecs[4] = '{2'b11, 4'd0,  4'd0,  4'd7,  4'd7,  0, 2'b01, 1'b0, 5'd0,  1'b0, 3};
        vecs[5] = '{2'b01, 4'd2,  4'd4,  4'd0,  4'd0,  1, 2'b01, 1'b0, 5'd6,  1'b0, 6};
        vecs[6] = '{2'b10, 4'd0,  4'd0,  4'd3,  4'd5,  2, 2'b10, 1'b1, 5'd8,  1'b1, 9};
        vecs[7] = '{2'b01, 4'd15, 4'd15, 4'd0,  4'd0,  0, 2'b01, 1'b0, 5'd30, 1'b0, 3};

        rst = 1'b1; req = 2'b00;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_rv", 32'(resp_valid), 32'd0);
        check("rst_fault", 32'(resp_fault), 32'd0);
        check("rst_id", 32'(resp_id), 32'd0);
        check("rst_sum", 32'(resp_sum), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_add_a", 32'(add_a), 32'd0);
        check("rst_add_b", 32'(add_b), 32'd0);
        rst = 1'b0;

        foreach (vecs[i]) run_op(vecs[i]);

        // Reset during PASS2 abandons the op and restores the pointer.
        @(negedge clk);
        mode = 0; a0 = 4'd6; b0 = 4'd3; req = 2'b01;
        wait_gnt(got);
        check("ab_gnt", 32'(gnt), 32'd1);
        check("ab_p1_a", 32'(add_a), 32'd6);
        check("ab_p1_b", 32'(add_b), 32'd3);
        @(negedge clk);
        check("ab_p2_a", 32'(add_a), 32'd3);
        check("ab_p2_b", 32'(add_b), 32'd6);
        rst = 1'b1; req = 2'b11;
        a0 = 4'd1; b0 = 4'd2; a1 = 4'd15; b1 = 4'd15;
        @(negedge clk);
        rst = 1'b0;
        check("ab_busy", 32'(busy), 32'd0);
        check("ab_rv", 32'(resp_valid), 32'd0);

        // req=11 held: grants alternate every 4 cycles, starting with requester 0.
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            eg = (c % 4 != 0) ? 2'b00 : (((c / 4) % 2 == 0) ? 2'b01 : 2'b10);
            check("rr_gnt", 32'(gnt), 32'(eg));
            check("rr_rv", 32'(resp_valid), (c % 4 == 3) ? 32'd1 : 32'd0);
            if (c == 3) begin
                check("rr_sum0", 32'(resp_sum), 32'd3);
                check("rr_id0", 32'(resp_id), 32'd0);
            end
            if (c == 7) begin
                check("rr_sum1", 32'(resp_sum), 32'd30);
                check("rr_id1", 32'(resp_id), 32'd1);
            end
        end
        req = 2'b00;
        drain();

        // A request raised while busy waits for the response cycle.
        @(negedge clk);
        req = 2'b10; a1 = 4'd1; b1 = 4'd1;
        wait_gnt(got);
        check("bz_gnt1", 32'(gnt), 32'd2);
        req = 2'b00;
        @(negedge clk);
        req = 2'b01; a0 = 4'd5; b0 = 4'd5;
        for (int l = 2; l <= 4; l++) begin
            @(negedge clk);
            if (l < 4) check("bz_nogrant", 32'(gnt), 32'd0);
            if (l == 3) begin
                check("bz_rv", 32'(resp_valid), 32'd1);
                check("bz_sum", 32'(resp_sum), 32'd2);
                check("bz_id", 32'(resp_id), 32'd1);
            end
            if (l == 4) check("bz_gnt0", 32'(gnt), 32'd1);
        end
        req = 2'b00;
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (resp_valid) got = 1;
        end
        check("bz_resp_seen", 32'(got), 32'd1);
        check("bz_sum2", 32'(resp_sum), 32'd10);
        check("bz_id2", 32'(resp_id), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/addr4u_redundant_sched.md
ADDR4U_REDUNDANT_SCHED -- requirements
Module: addr4u_redundant_sched

Interface
REQ-001 SHALL have parameter MAX_RETRY, default 2, meaning the number of re-executions allowed after a mismatch (range 0..7).
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port req  input  2  request level per requester; held high until granted.
REQ-005 SHALL have ports a0, b0  input  4 each  requester-0 unsigned operands; a1, b1  input  4 each  requester-1 unsigned operands.
REQ-006 SHALL have port gnt  output  2  one-hot, single-cycle grant pulse; operands are captured on the same edge that raises it.
REQ-007 SHALL have ports add_a, add_b  output  4 each  operands driven to the shared external 4-bit adder, and add_o  input  5  adder result {carry, sum[3:0]}.
REQ-008 SHALL have ports resp_valid  output  1  one-cycle result strobe; resp_id  output  1  requester served; resp_sum  output  5  result; resp_fault  output  1  mismatch not resolved.
REQ-009 SHALL have port busy  output  1  high whenever FSM is not IDLE.

Function
REQ-010 SHALL implement FSM states IDLE, PASS1, PASS2, CHECK.
REQ-011 IDLE with any req bit high SHALL, at the next edge, latch the winner's operands, assert gnt for one cycle, clear retry count, and go to PASS1.
REQ-012 Arbitration SHALL be round-robin: a single request wins outright; on simultaneous requests, the requester not served last wins; the last-served pointer resets to 1, so requester 0 wins first.
REQ-013 Requests arriving while busy SHALL NOT be granted; they remain pending until IDLE.
REQ-014 PASS1 SHALL drive add_a=opA, add_b=opB, register add_o into r1 at the edge, and go to PASS2.
REQ-015 PASS2 SHALL drive add_a=opB, add_b=opA (swapped), register add_o into r2, and go to CHECK.
REQ-016 add_a and add_b SHALL be 0 in IDLE and CHECK.
REQ-017 CHECK with r1==r2 SHALL, at the next edge, assert resp_valid with resp_sum=r1, resp_fault=0, resp_id=winner, and return to IDLE.
REQ-018 CHECK with r1!=r2 and retry count < MAX_RETRY SHALL increment the count and go to PASS1 with no response.
REQ-019 CHECK with r1!=r2 and retry count == MAX_RETRY SHALL assert resp_valid with resp_sum=r1, resp_fault=1, and return to IDLE.
REQ-020 Latency without retry SHALL be exactly 3 cycles from the gnt cycle to the resp_valid cycle; each retry SHALL add exactly 3 cycles.
REQ-021 The response cycle SHALL be IDLE, so a pending request SHALL be granted at the edge ending the resp_valid cycle; peak throughput is one operation per 4 cycles.
REQ-022 resp_sum, resp_id and resp_fault SHALL hold their last values between strobes; resp_valid and gnt SHALL be high for exactly one cycle per event.
REQ-023 No arithmetic SHALL be performed internally; the result width is 5 bits as supplied by add_o, with no truncation.
REQ-024 Symmetric faults (identical r1 and r2) SHALL go undetected; this is an accepted limitation.

Reset
REQ-025 rst high at an edge SHALL force IDLE, gnt=0, resp_valid=0, resp_fault=0, resp_id=0, resp_sum=0, busy=0, retry count=0, and pointer=1.
REQ-026 Reset mid-operation SHALL abandon the operation with no response issued; the abandoned requester SHALL re-request.

Verification
REQ-027 req=01, a0=9, b0=7, ideal adder -> gnt=01 for one cycle; resp_valid 3 cycles later, resp_sum=16, resp_id=0, resp_fault=0.
REQ-028 req=11 held continuously, a1=15, b1=15 -> grants alternate 01, 10, 01 every 4 cycles; requester-1 resp_sum=30.
REQ-029 Adder model with bit0 stuck-at-1 in PASS2 of the first attempt only, operands 2+4 -> one retry; resp 6 cycles after gnt, resp_sum=6, resp_fault=0.
REQ-030 Persistent PASS2-only fault, MAX_RETRY=2, operands 3+5 -> resp 9 cycles after gnt, resp_fault=1, resp_sum=8 (r1).
REQ-031 rst asserted during PASS2 -> no resp_valid, busy=0 the next cycle; with req=11, the next grant goes to requester 0.
REQ-032 req0 rises while busy -> no gnt until resp_valid of the current operation; gnt issued on the edge ending the resp_valid cycle.
